// File: rtl/raytracing_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : raytracing_job_scheduler
// Brief    : Walks a frame in CHUNK-pixel row segments: launches the worker
//            bank, waits for it, then drains the worker buffers to the
//            framebuffer in ascending address order. Optional chunk watchdog
//            is enabled by defining RT_SCHED_WATCHDOG_EN.
//            worker_buffer packing: worker w, job k at [(w*JOBS_SUBDIVISION+k)*12 +: 12].
// Revision : 1.0 - initial release
// ============================================================================
module raytracing_job_scheduler #(
    parameter int N_WORKERS        = 4,
    parameter int JOBS_SUBDIVISION = 8,
    parameter int SCREEN_W         = 640,
    parameter int SCREEN_H         = 480,
    parameter int WATCHDOG_CYCLES  = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   frame_start,
    output logic                                   frame_busy,
    output logic                                   frame_done,
    output logic                                   worker_activate,
    output logic [N_WORKERS*12-1:0]                worker_x,
    output logic [11:0]                            worker_y,
    input  logic [N_WORKERS-1:0]                   worker_busy,
    input  logic [N_WORKERS*JOBS_SUBDIVISION*12-1:0] worker_buffer,
    output logic                                   fb_valid,
    input  logic                                   fb_ready,
    output logic [18:0]                            fb_addr,
    output logic [11:0]                            fb_data,
    output logic                                   watchdog_err
);

    localparam int CHUNK = N_WORKERS * JOBS_SUBDIVISION;
    localparam int IW    = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int WW    = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
    localparam int JW    = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_launch = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_drain  = 3'd3;
    localparam logic [2:0] c_st_next   = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [11:0]             base_q, base_d;
    logic [11:0]             y_q, y_d;
    logic [18:0]             row_q, row_d;
    logic [WW-1:0]           widx_q, widx_d;
    logic [JW-1:0]           job_q, job_d;
    logic                    activate_q, activate_d;
    logic [N_WORKERS*12-1:0] worker_x_q, worker_x_d;
    logic [11:0]             worker_y_q, worker_y_d;
    logic                    fb_valid_q, fb_valid_d;
    logic [18:0]             fb_addr_q, fb_addr_d;
    logic [11:0]             fb_data_q, fb_data_d;
    logic                    frame_busy_q, frame_busy_d;
    logic                    frame_done_q, frame_done_d;

    logic                    w_wd_expire;
    logic                    w_zero_fill;
    logic [WW-1:0]           w_adv_widx;
    logic [JW-1:0]           w_adv_job;
    logic [IW-1:0]           w_adv_idx;
    logic                    w_last;
    logic [11:0]             w_base_inc;
    logic [11:0]             w_y_inc;
    logic [11:0]             w_pix [CHUNK];

    for (genvar g = 0; g < CHUNK; g++) begin : g_pix
        assign w_pix[g] = worker_buffer[g*12 +: 12];
    end

    // Drain order is worker-fastest: pixel p maps to worker p%N, job p/N.
    always_comb begin
        if (widx_q == WW'(N_WORKERS - 1)) begin
            w_adv_widx = '0;
            w_adv_job  = job_q + JW'(1);
        end else begin
            w_adv_widx = widx_q + WW'(1);
            w_adv_job  = job_q;
        end
        w_adv_idx = IW'(w_adv_widx) * IW'(JOBS_SUBDIVISION) + IW'(w_adv_job);
        w_last    = (widx_q == WW'(N_WORKERS - 1)) && (job_q == JW'(JOBS_SUBDIVISION - 1));
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        y_d          = y_q;
        row_d        = row_q;
        widx_d       = widx_q;
        job_d        = job_q;
        activate_d   = activate_q;
        worker_x_d   = worker_x_q;
        worker_y_d   = worker_y_q;
        fb_valid_d   = fb_valid_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        frame_busy_d = frame_busy_q;
        frame_done_d = 1'b0;
        w_base_inc   = base_q + 12'(CHUNK);
        w_y_inc      = y_q + 12'd1;

        case (state_q)
            c_st_idle: begin
                if (frame_start) begin
                    state_d      = c_st_launch;
                    base_d       = '0;
                    y_d          = '0;
                    row_d        = '0;
                    frame_busy_d = 1'b1;
                end
            end
            c_st_launch: begin
                state_d = c_st_wait;
            end
            c_st_wait: begin
                if ((worker_busy == '0) || w_wd_expire) begin
                    state_d    = c_st_drain;
                    activate_d = 1'b0;
                    widx_d     = '0;
                    job_d      = '0;
                    fb_valid_d = 1'b1;
                    fb_addr_d  = row_q + 19'(base_q);
                    fb_data_d  = (w_wd_expire || w_zero_fill) ? 12'd0 : w_pix[0];
                end
            end
            c_st_drain: begin
                if (fb_ready) begin
                    if (w_last) begin
                        state_d    = c_st_next;
                        fb_valid_d = 1'b0;
                    end else begin
                        widx_d    = w_adv_widx;
                        job_d     = w_adv_job;
                        fb_addr_d = fb_addr_q + 19'd1;
                        fb_data_d = w_zero_fill ? 12'd0 : w_pix[w_adv_idx];
                    end
                end
            end
            c_st_next: begin
                if (w_base_inc == 12'(SCREEN_W)) begin
                    if (w_y_inc == 12'(SCREEN_H)) begin
                        state_d      = c_st_done;
                        frame_done_d = 1'b1;
                        frame_busy_d = 1'b0;
                    end else begin
                        state_d = c_st_launch;
                        base_d  = '0;
                        y_d     = w_y_inc;
                        row_d   = row_q + 19'(SCREEN_W);
                    end
                end else begin
                    state_d = c_st_launch;
                    base_d  = w_base_inc;
                end
            end
            c_st_done: begin
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase

        // Coordinates are loaded as LAUNCH is entered so they are stable for the whole launch.
        if (state_d == c_st_launch) begin
            activate_d = 1'b1;
            worker_y_d = y_d;
            for (int w = 0; w < N_WORKERS; w++) begin
                worker_x_d[w*12 +: 12] = base_d + 12'(w);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_st_idle;
            base_q       <= '0;
            y_q          <= '0;
            row_q        <= '0;
            widx_q       <= '0;
            job_q        <= '0;
            activate_q   <= 1'b0;
            worker_x_q   <= '0;
            worker_y_q   <= '0;
            fb_valid_q   <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            y_q          <= y_d;
            row_q        <= row_d;
            widx_q       <= widx_d;
            job_q        <= job_d;
            activate_q   <= activate_d;
            worker_x_q   <= worker_x_d;
            worker_y_q   <= worker_y_d;
            fb_valid_q   <= fb_valid_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef RT_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(WATCHDOG_CYCLES + 1);

    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           wd_err_q, wd_err_d;
    logic           zero_q, zero_d;

    // A timed-out chunk still drains in full, but with black pixels.
    always_comb begin
        wd_cnt_d    = wd_cnt_q;
        wd_err_d    = wd_err_q;
        zero_d      = zero_q;
        w_wd_expire = (state_q == c_st_wait) && (worker_busy != '0) &&
                      (wd_cnt_q == WDW'(WATCHDOG_CYCLES - 1));
        if (state_q == c_st_launch) begin
            wd_cnt_d = '0;
        end else if (state_q == c_st_wait) begin
            wd_cnt_d = wd_cnt_q + WDW'(1);
        end
        if ((state_q == c_st_idle) && frame_start) begin
            wd_err_d = 1'b0;
        end else if (w_wd_expire) begin
            wd_err_d = 1'b1;
        end
        if (w_wd_expire) begin
            zero_d = 1'b1;
        end else if (state_q == c_st_next) begin
            zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
            zero_q   <= zero_d;
        end
    end

    assign w_zero_fill  = zero_q;
    assign watchdog_err = wd_err_q;
`else
    assign w_wd_expire  = 1'b0;
    assign w_zero_fill  = 1'b0;
    assign watchdog_err = 1'b0;
`endif

    assign frame_busy      = frame_busy_q;
    assign frame_done      = frame_done_q;
    assign worker_activate = activate_q;
    assign worker_x        = worker_x_q;
    assign worker_y        = worker_y_q;
    assign fb_valid        = fb_valid_q;
    assign fb_addr         = fb_addr_q;
    assign fb_data         = fb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_raytracing_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_raytracing_job_scheduler
// Brief    : Directed bench for raytracing_job_scheduler with behavioural
//            workers; watchdog scenario runs when RT_SCHED_WATCHDOG_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_raytracing_job_scheduler;

    localparam int N    = 4;
    localparam int J    = 8;
    localparam int SW   = 64;
    localparam int SH   = 2;
    localparam int WD   = 16;
    localparam int CH   = N * J;
    localparam int NPIX = SW * SH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic              frame_busy;
    logic              frame_done;
    logic              worker_activate;
    logic [N*12-1:0]   worker_x;
    logic [11:0]       worker_y;
    logic [N-1:0]      worker_busy;
    logic [N*J*12-1:0] worker_buffer = '0;
    logic              fb_valid;
    logic              fb_ready = 1'b0;
    logic [18:0]       fb_addr;
    logic [11:0]       fb_data;
    logic              watchdog_err;

    always #5 clk = ~clk;

    raytracing_job_scheduler #(
        .N_WORKERS(N), .JOBS_SUBDIVISION(J), .SCREEN_W(SW), .SCREEN_H(SH), .WATCHDOG_CYCLES(WD)
    ) u_dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_busy(frame_busy),
        .frame_done(frame_done), .worker_activate(worker_activate), .worker_x(worker_x),
        .worker_y(worker_y), .worker_busy(worker_busy), .worker_buffer(worker_buffer),
        .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_addr(fb_addr), .fb_data(fb_data),
        .watchdog_err(watchdog_err)
    );

    // Worker model: busy from the cycle after activate is seen, for 4+w cycles.
    logic [N-1:0] m_busy  = '0;
    logic [N-1:0] m_armed = '0;
    logic [N-1:0] stuck   = '0;
    int           m_cnt [N];
    assign worker_busy = m_busy | stuck;

    always @(posedge clk) begin
        for (int w = 0; w < N; w++) begin
            if (rst || !worker_activate) begin
                m_armed[w] <= 1'b0;
                m_busy[w]  <= 1'b0;
            end else if (!m_armed[w]) begin
                m_armed[w] <= 1'b1;
                m_busy[w]  <= 1'b1;
                m_cnt[w]   <= 3 + w;
            end else if (m_cnt[w] != 0) begin
                m_cnt[w] <= m_cnt[w] - 1;
            end else begin
                m_busy[w] <= 1'b0;
            end
        end
    end

    int          checks   = 0;
    int          failures = 0;
    logic [18:0] wr_addr [$];
    logic [11:0] wr_data [$];
    logic [47:0] lx [$];
    logic [11:0] ly [$];
    int          done_cnt;
    int          stab_err;
    int          act_pre_err;

    function automatic logic [11:0] pat(input logic [18:0] a);
        int p;
        p = int'(a) % CH;
        return {4'(p % N), 4'(p / N), 4'hA};
    endfunction

    function automatic int order_errs();
        int e;
        e = 0;
        foreach (wr_addr[i]) if (wr_addr[i] !== 19'(i)) e++;
        return e;
    endfunction

    task automatic load_pattern();
        for (int w = 0; w < N; w++)
            for (int k = 0; k < J; k++)
                worker_buffer[(w*J+k)*12 +: 12] = {4'(w), 4'(k), 4'hA};
    endtask

    task automatic run_frame(input bit toggle_ready, input bit pulse_in_drain);
        int          cyc;
        int          after;
        bit          done_seen;
        bit          prev_hold;
        bit          prev_act;
        bit          err_seen;
        bit          pulsed;
        bit          pulse_next;
        bit          timed_out;
        logic [18:0] paddr;
        logic [11:0] pdata;
        wr_addr.delete(); wr_data.delete(); lx.delete(); ly.delete();
        done_cnt = 0; stab_err = 0; act_pre_err = 0;
        cyc = 0; after = 0; done_seen = 0; prev_hold = 0; prev_act = 0;
        err_seen = 0; pulsed = 0; pulse_next = 0; timed_out = 0;
        paddr = '0; pdata = '0;
        @(posedge clk); #1;
        frame_start = 1'b1;
        fb_ready    = 1'b1;
        while (1) begin
            @(negedge clk);
            if (fb_valid && fb_ready) begin
                wr_addr.push_back(fb_addr);
                wr_data.push_back(fb_data);
            end
            if (prev_hold && (!fb_valid || fb_addr !== paddr || fb_data !== pdata)) stab_err++;
            prev_hold = fb_valid && !fb_ready;
            paddr = fb_addr;
            pdata = fb_data;
            if (worker_activate && !prev_act) begin
                lx.push_back(worker_x);
                ly.push_back(worker_y);
            end
            prev_act = worker_activate;
            if (!err_seen) begin
                if (watchdog_err) err_seen = 1;
                else if (worker_activate) act_pre_err++;
            end
            if (frame_done) begin
                done_cnt++;
                done_seen = 1;
            end
            if (pulse_in_drain && !pulsed && fb_valid && fb_addr == 19'd40) begin
                pulse_next = 1;
                pulsed = 1;
            end
            if (done_seen) begin
                after++;
                if (after >= 5) break;
            end
            cyc++;
            if (cyc > 4000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            frame_start = pulse_next;
            pulse_next  = 0;
            fb_ready    = toggle_ready ? ~fb_ready : 1'b1;
        end
        frame_start = 1'b0;
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL frame_timeout: got %0d cycles without frame_done, want done within 4000", cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({frame_busy, frame_done, worker_activate, fb_valid, watchdog_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {frame_busy, frame_done, worker_activate, fb_valid, watchdog_err});
        end
        checks++;
        if ({worker_x, worker_y, fb_addr, fb_data} !== '0) begin
            failures++;
            $display("FAIL reset_data: got x=%h y=%h addr=%h data=%h want all 0",
                     worker_x, worker_y, fb_addr, fb_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_midframe_reset();
        int n;
        load_pattern();
        @(posedge clk); #1;
        frame_start = 1'b1;
        fb_ready    = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        n = 0;
        while (!(fb_valid && fb_addr >= 19'd5) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL midframe_reach_drain: got no drain within %0d cycles, want addr>=5", n);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({frame_busy, frame_done, worker_activate, fb_valid, watchdog_err} !== 5'b0 ||
            {worker_x, worker_y, fb_addr, fb_data} !== '0) begin
            failures++;
            $display("FAIL midframe_reset_outputs: got busy=%b act=%b valid=%b addr=%h data=%h want all 0",
                     frame_busy, worker_activate, fb_valid, fb_addr, fb_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({frame_busy, worker_activate, fb_valid} !== 3'b0) begin
            failures++;
            $display("FAIL midframe_stays_idle: got busy=%b act=%b valid=%b want 000",
                     frame_busy, worker_activate, fb_valid);
        end
    endtask

    task automatic test_basic_frame();
        int derr;
        load_pattern();
        run_frame(1'b0, 1'b0);
        checks++;
        if (wr_addr.size() != NPIX) begin
            failures++;
            $display("FAIL basic_write_count: got %0d want %0d", wr_addr.size(), NPIX);
        end
        checks++;
        if (order_errs() != 0) begin
            failures++;
            $display("FAIL basic_addr_order: got %0d out-of-order addresses want 0 (first addr %h)",
                     order_errs(), wr_addr.size() > 0 ? wr_addr[0] : 19'h7ffff);
        end
        derr = 0;
        foreach (wr_data[i]) if (wr_data[i] !== pat(wr_addr[i])) derr++;
        checks++;
        if (derr != 0) begin
            failures++;
            $display("FAIL basic_data: got %0d wrong pixels want 0", derr);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL basic_frame_done: got %0d pulses want 1", done_cnt);
        end
        checks++;
        if (lx.size() != 4) begin
            failures++;
            $display("FAIL basic_launch_count: got %0d want 4", lx.size());
        end
        checks++;
        if (lx[0] !== 48'h003_002_001_000 || ly[0] !== 12'd0) begin
            failures++;
            $display("FAIL basic_first_launch: got x=%h y=%h want x=003002001000 y=000", lx[0], ly[0]);
        end
        checks++;
        if (lx[1] !== 48'h023_022_021_020 || ly[1] !== 12'd0) begin
            failures++;
            $display("FAIL basic_second_launch: got x=%h y=%h want x=023022021020 y=000", lx[1], ly[1]);
        end
        checks++;
        if (lx[2] !== 48'h003_002_001_000 || ly[2] !== 12'd1) begin
            failures++;
            $display("FAIL basic_row_wrap_launch: got x=%h y=%h want x=003002001000 y=001", lx[2], ly[2]);
        end
        checks++;
        if (frame_busy !== 1'b0 || watchdog_err !== 1'b0) begin
            failures++;
            $display("FAIL basic_end_state: got busy=%b err=%b want 0 0", frame_busy, watchdog_err);
        end
    endtask

    task automatic test_single_pixel();
        int bad;
        int hits;
        worker_buffer = '0;
        worker_buffer[(1*J+2)*12 +: 12] = 12'hF00;
        run_frame(1'b0, 1'b0);
        bad = 0; hits = 0;
        foreach (wr_data[i]) begin
            if (int'(wr_addr[i]) % CH == 9) begin
                hits++;
                if (wr_data[i] !== 12'hF00) bad++;
            end else if (wr_data[i] !== 12'h000) bad++;
        end
        checks++;
        if (bad != 0 || hits != 4) begin
            failures++;
            $display("FAIL single_pixel: got %0d wrong pixels, %0d hits on addr 9+32k want 0 wrong, 4 hits",
                     bad, hits);
        end
        checks++;
        if (wr_addr.size() != NPIX) begin
            failures++;
            $display("FAIL single_write_count: got %0d want %0d", wr_addr.size(), NPIX);
        end
    endtask

    task automatic test_ready_toggle();
        int derr;
        load_pattern();
        run_frame(1'b1, 1'b0);
        derr = 0;
        foreach (wr_data[i]) if (wr_data[i] !== pat(wr_addr[i])) derr++;
        checks++;
        if (wr_addr.size() != NPIX || order_errs() != 0 || derr != 0) begin
            failures++;
            $display("FAIL toggle_writes: got count=%0d order_errs=%0d data_errs=%0d want %0d 0 0",
                     wr_addr.size(), order_errs(), derr, NPIX);
        end
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL toggle_stable: got %0d unstable stall cycles want 0", stab_err);
        end
    endtask

    task automatic test_start_in_drain();
        load_pattern();
        run_frame(1'b0, 1'b1);
        checks++;
        if (done_cnt != 1 || wr_addr.size() != NPIX || order_errs() != 0) begin
            failures++;
            $display("FAIL start_in_drain: got done=%0d count=%0d order_errs=%0d want 1 %0d 0",
                     done_cnt, wr_addr.size(), order_errs(), NPIX);
        end
    endtask

`ifdef RT_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        int nz;
        load_pattern();
        stuck = 4'b0100;
        run_frame(1'b0, 1'b0);
        stuck = '0;
        nz = 0;
        foreach (wr_data[i]) if (wr_data[i] !== 12'h000) nz++;
        checks++;
        if (watchdog_err !== 1'b1) begin
            failures++;
            $display("FAIL wd_err_sticky: got %b want 1", watchdog_err);
        end
        checks++;
        if (act_pre_err != 1 + WD) begin
            failures++;
            $display("FAIL wd_latency: got %0d activate cycles before err want %0d", act_pre_err, 1 + WD);
        end
        checks++;
        if (nz != 0 || wr_addr.size() != NPIX || order_errs() != 0 || done_cnt != 1) begin
            failures++;
            $display("FAIL wd_drain: got nonzero=%0d count=%0d order_errs=%0d done=%0d want 0 %0d 0 1",
                     nz, wr_addr.size(), order_errs(), done_cnt, NPIX);
        end
        run_frame(1'b0, 1'b0);
        checks++;
        if (watchdog_err !== 1'b0) begin
            failures++;
            $display("FAIL wd_clear_on_start: got %b want 0", watchdog_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_midframe_reset();
        test_basic_frame();
        test_single_pixel();
        test_ready_toggle();
        test_start_in_drain();
`ifdef RT_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
